keypad_scanner: RTL and testbench

Column scanner and debouncer for the 4x4 hex keypad. It drives the keypad column lines one at a time and synchronizes the active-low row lines. It confirms a single pressed key over several scan samples, then presents a stable `keyboard` row code and `counter` column index to the downstream hex encoder, plus a one-cycle `key_valid` strobe and a `key_held` level.

---
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with two-flop row synchronizer and tick-sampled debounce.
// Presents a stable row code and column index to the hex encoder while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [1:0] counter,
    output logic [3:0] keyboard,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [3:0]    sync1;
    logic [3:0]    rs;
    logic [DW-1:0] dwell;
    logic          tick;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          code_ok;
    logic          idle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 4'hF;
            rs    <= 4'hF;
        end else begin
            sync1 <= rows;
            rs    <= sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     dwell <= '0;
        else if (tick) dwell <= '0;
        else           dwell <= dwell + DW'(1);
    end

    assign tick    = (dwell == DWELL_LAST);
    assign idle    = (rs == 4'hF);
    assign code_ok = (rs == 4'b1110) || (rs == 4'b1101) || (rs == 4'b1011) || (rs == 4'b0111);
    // Saturating so a large DEBOUNCE never wraps back below the threshold.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_SCAN;
            cnt       <= '0;
            cols      <= 4'b1110;
            counter   <= 2'd0;
            keyboard  <= 4'hF;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    S_SCAN: begin
                        if (code_ok) begin
                            keyboard <= rs;
                            cnt      <= CW'(1);
                            if (DEBOUNCE == 1) begin
                                state     <= S_HOLD;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= S_DEB;
                            end
                        end else begin
                            cols    <= {cols[2:0], cols[3]};
                            counter <= counter + 2'd1;
                        end
                    end
                    S_DEB: begin
                        if (rs == keyboard) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                state     <= S_HOLD;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else begin
                            keyboard <= 4'hF;
                            cols     <= {cols[2:0], cols[3]};
                            counter  <= counter + 2'd1;
                            state    <= S_SCAN;
                        end
                    end
                    S_HOLD: begin
                        if (idle) begin
                            cnt <= CW'(1);
                            if (DEBOUNCE == 1) begin
                                key_held <= 1'b0;
                                keyboard <= 4'hF;
                                cols     <= {cols[2:0], cols[3]};
                                counter  <= counter + 2'd1;
                                state    <= S_SCAN;
                            end else begin
                                state <= S_REL;
                            end
                        end
                    end
                    S_REL: begin
                        if (idle) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                key_held <= 1'b0;
                                keyboard <= 4'hF;
                                cols     <= {cols[2:0], cols[3]};
                                counter  <= counter + 2'd1;
                                state    <= S_SCAN;
                            end
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad presses against a tick-level reference model; a negedge monitor
// pops per-cycle expectations and accepted-key events from scoreboard queues.
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 3;

    typedef struct packed {
        logic [3:0] cols;
        logic [1:0] counter;
        logic [3:0] keyboard;
        logic       kv;
        logic       kh;
    } obs_t;

    localparam obs_t RST_OBS = '{cols: 4'b1110, counter: 2'd0, keyboard: 4'hF, kv: 1'b0, kh: 1'b0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [1:0] counter;
    logic [3:0] keyboard;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (
        .clock(clock), .reset(reset), .rows(rows), .cols(cols),
        .counter(counter), .keyboard(keyboard), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clock = ~clock;

    // Keypad: a pressed key pulls its row low only while its column is driven.
    logic       k_on = 1'b0, k2_on = 1'b0;
    logic [1:0] k_r = 2'd0, k_c = 2'd0, k2_r = 2'd0;
    always_comb begin
        rows = 4'hF;
        if (k_on && !cols[k_c])  rows[k_r]  = 1'b0;
        if (k2_on && !cols[k_c]) rows[k2_r] = 1'b0;
    end

    int vectors = 0;
    int miscompares = 0;

    obs_t       exp_q[$];
    logic [5:0] acc_q[$];

    function automatic obs_t mk_obs(int col, logic [3:0] code, bit kv, bit kh);
        logic [3:0] c;
        c = 4'hF;
        c[col] = 1'b0;
        return '{cols: c, counter: 2'(col), keyboard: code, kv: kv, kh: kh};
    endfunction

    // Reference model: rs is the rows value two edges old; every S-th edge is a tick.
    initial begin : model_p
        int         m_edge, m_phase, m_col, m_streak;
        logic [3:0] m_code, cur;
        logic [3:0] m_hist[$];
        bit         m_held, kv, tick, onehot;
        m_edge = 0; m_phase = 0; m_col = 0; m_streak = 0; m_code = 4'hF; m_held = 0;
        m_hist = '{4'hF, 4'hF};
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_edge = 0; m_phase = 0; m_col = 0; m_streak = 0; m_code = 4'hF; m_held = 0;
                m_hist = '{4'hF, 4'hF};
                exp_q.delete();
                acc_q.delete();
            end else begin
                cur = m_hist.pop_front();
                m_hist.push_back(rows);
                tick = (m_edge % S) == S - 1;
                m_edge++;
                kv = 0;
                if (tick) begin
                    onehot = cur inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
                    case (m_phase)
                        0: if (onehot) begin
                               m_code = cur; m_streak = 1; m_phase = 1;
                           end else m_col = (m_col + 1) % 4;
                        1: if (cur == m_code) m_streak++;
                           else begin m_code = 4'hF; m_col = (m_col + 1) % 4; m_phase = 0; end
                        2: if (cur == 4'hF) begin m_streak = 1; m_phase = 3; end
                        default: if (cur == 4'hF) m_streak++; else m_phase = 2;
                    endcase
                    if (m_phase == 1 && m_streak >= D) begin
                        m_phase = 2; m_held = 1; kv = 1;
                        acc_q.push_back({2'(m_col), m_code});
                    end else if (m_phase == 3 && m_streak >= D) begin
                        m_phase = 0; m_held = 0; m_code = 4'hF; m_col = (m_col + 1) % 4;
                    end
                end
                exp_q.push_back(mk_obs(m_col, m_code, kv, m_held));
            end
        end
    end

    initial begin : monitor_p
        obs_t       exp_cur, act;
        logic [5:0] ev;
        exp_cur = RST_OBS;
        forever begin
            @(negedge clock);
            if (reset) exp_cur = RST_OBS;
            else if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
            act = '{cols: cols, counter: counter, keyboard: keyboard, kv: key_valid, kh: key_held};
            vectors++;
            if (act !== exp_cur) begin
                miscompares++;
                $display("FAIL outputs t=%0t got cols=%b cnt=%0d kb=%b kv=%b kh=%b, expected cols=%b cnt=%0d kb=%b kv=%b kh=%b",
                         $time, act.cols, act.counter, act.keyboard, act.kv, act.kh,
                         exp_cur.cols, exp_cur.counter, exp_cur.keyboard, exp_cur.kv, exp_cur.kh);
            end
            if (!reset && key_valid === 1'b1) begin
                vectors++;
                if (acc_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL key_event t=%0t unexpected key_valid cnt=%0d kb=%b", $time, counter, keyboard);
                end else begin
                    ev = acc_q.pop_front();
                    if ({counter, keyboard} !== ev) begin
                        miscompares++;
                        $display("FAIL key_event t=%0t got cnt=%0d kb=%b, expected cnt=%0d kb=%b",
                                 $time, counter, keyboard, ev[5:4], ev[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic press(logic [1:0] r, logic [1:0] c);
        k_r = r; k_c = c; k_on = 1'b1;
    endtask

    task automatic release_all();
        k_on = 1'b0; k2_on = 1'b0;
    endtask

    initial begin : stim_p
        int  mode, n;
        bit  seen;
        cyc(3);
        reset = 1'b0;
        cyc(40);                                   // idle scan
        press(2'd1, 2'd2); cyc(60);                // clean press
        release_all(); cyc(9);                     // partial release, then glitch
        press(2'd1, 2'd2); cyc(30);
        release_all(); cyc(40);
        press(2'd0, 2'd1); cyc(6); release_all(); cyc(30);   // bounce
        k_c = 2'd3; k_r = 2'd0; k2_r = 2'd1; k_on = 1'b1; k2_on = 1'b1;
        cyc(60); release_all(); cyc(10);           // two keys in one column
        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: cyc($urandom_range(1, 30));
                1: begin
                    press(2'($urandom), 2'($urandom)); cyc($urandom_range(1, 12));
                    release_all(); cyc($urandom_range(1, 20));
                end
                2: begin
                    press(2'($urandom), 2'($urandom)); cyc($urandom_range(20, 80));
                    if ($urandom_range(0, 1) == 1) begin
                        k_on = 1'b0; cyc($urandom_range(1, 12));
                        k_on = 1'b1; cyc($urandom_range(10, 40));
                    end
                    release_all(); cyc($urandom_range(10, 40));
                end
                default: begin
                    k_c = 2'($urandom); k_r = 2'($urandom);
                    k2_r = k_r ^ 2'($urandom_range(1, 3));
                    k_on = 1'b1; k2_on = 1'b1;
                    cyc($urandom_range(10, 40));
                    release_all(); cyc($urandom_range(1, 20));
                end
            endcase
        end
        release_all(); cyc(40);

        // Asynchronous reset while a key is held.
        press(2'd2, 2'd0);
        seen = 0;
        n = 0;
        while (!seen && n < 200) begin
            cyc(1);
            n++;
            if (key_held === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL hold_wait key_held never rose within 200 cycles, got %b expected 1", key_held);
        end
        cyc(5);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({cols, counter, keyboard, key_valid, key_held} !== RST_OBS) begin
            miscompares++;
            $display("FAIL async_reset got cols=%b cnt=%0d kb=%b kv=%b kh=%b, expected cols=1110 cnt=0 kb=1111 kv=0 kh=0",
                     cols, counter, keyboard, key_valid, key_held);
        end
        release_all();
        cyc(2);
        reset = 1'b0;
        cyc(40);

        vectors++;
        if (acc_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got %0d unmatched predicted key_valid, expected 0", acc_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
